// File: rtl/bp_nonsynth_io_cfg_sink.sv
// IO endpoint behind the NBF loader: config-device writes drive the freeze register,
// all other commands read or write a small dword backing store. One response per command.
//
//   state  | meaning
//   IDLE   | waiting for a command; yumi follows valid
//   EXEC   | one cycle: decode, access config/store, register response
//   RESP   | response valid, held until downstream ready
module bp_nonsynth_io_cfg_sink #(
  parameter int paddr_width_p    = 40,
  parameter int dword_width_p    = 64,
  parameter int lce_id_width_p   = 4,
  parameter int mem_els_p        = 1024,
  parameter int cfg_dev_width_p  = 4,
  parameter int cfg_addr_width_p = 16,
  parameter logic [cfg_dev_width_p-1:0]  cfg_dev_gp           = 4'h2,
  parameter logic [cfg_addr_width_p-1:0] bp_cfg_reg_freeze_gp = 16'h0008,
  localparam int cce_io_msg_width_lp = 2 + paddr_width_p + 2 + lce_id_width_p + dword_width_p
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [cce_io_msg_width_lp-1:0] io_cmd_i,
  input  logic                           io_cmd_v_i,
  output logic                           io_cmd_yumi_o,
  output logic [cce_io_msg_width_lp-1:0] io_resp_o,
  output logic                           io_resp_v_o,
  input  logic                           io_resp_ready_i,
  output logic                           freeze_o,
  output logic [31:0]                    wr_count_o
);

  localparam int lg_mem_els_lp = $clog2(mem_els_p);
  localparam int half_width_lp = dword_width_p / 2;

  localparam logic [1:0] e_cce_io_wr = 2'b01;
  localparam logic [1:0] e_io_size_8 = 2'b11;

  typedef struct packed {
    logic [1:0]                msg_type;
    logic [paddr_width_p-1:0]  addr;
    logic [1:0]                size;
    logic [lce_id_width_p-1:0] payload;
    logic [dword_width_p-1:0]  data;
  } io_msg_s;

  typedef enum logic [1:0] {e_idle, e_exec, e_resp} state_e;

  state_e  state_r;
  io_msg_s cmd_r, resp_r, resp_n;
  logic    resp_v_r;
  logic    freeze_r;
  logic [31:0] wr_count_r;

  logic [dword_width_p-1:0] mem [mem_els_p];

  logic                        is_wr, cfg_hit, hi_sel, is_size_8;
  logic [cfg_addr_width_p-1:0] cfg_addr;
  logic [lg_mem_els_lp-1:0]    mem_idx;
  logic [dword_width_p-1:0]    mem_rd, rd_data;

  assign is_wr     = (cmd_r.msg_type == e_cce_io_wr);
  assign cfg_hit   = (cmd_r.addr[paddr_width_p-1 -: cfg_dev_width_p] == cfg_dev_gp);
  assign cfg_addr  = cmd_r.addr[cfg_addr_width_p-1:0];
  assign mem_idx   = cmd_r.addr[3 +: lg_mem_els_lp];
  assign hi_sel    = cmd_r.addr[2];
  assign is_size_8 = (cmd_r.size == e_io_size_8);
  assign mem_rd    = mem[mem_idx];

  // Anything narrower than a dword behaves as a 32-bit half access
  always_comb begin
    rd_data = '0;
    if (cfg_hit) begin
      if (cfg_addr == bp_cfg_reg_freeze_gp)
        rd_data = {{(dword_width_p-1){1'b0}}, freeze_r};
    end else if (is_size_8) begin
      rd_data = mem_rd;
    end else if (hi_sel) begin
      rd_data = {{half_width_lp{1'b0}}, mem_rd[dword_width_p-1:half_width_lp]};
    end else begin
      rd_data = {{half_width_lp{1'b0}}, mem_rd[half_width_lp-1:0]};
    end
  end

  always_comb begin
    resp_n      = cmd_r;
    resp_n.data = is_wr ? '0 : rd_data;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= e_idle;
      cmd_r      <= '0;
      resp_r     <= '0;
      resp_v_r   <= 1'b0;
      freeze_r   <= 1'b1;
      wr_count_r <= '0;
    end else begin
      case (state_r)
        e_idle: begin
          if (io_cmd_v_i) begin
            cmd_r   <= io_cmd_i;
            state_r <= e_exec;
          end
        end
        e_exec: begin
          resp_r   <= resp_n;
          resp_v_r <= 1'b1;
          state_r  <= e_resp;
          if (is_wr) begin
            if (cfg_hit && (cfg_addr == bp_cfg_reg_freeze_gp))
              freeze_r <= cmd_r.data[0];
            if (wr_count_r != '1)
              wr_count_r <= wr_count_r + 32'd1;
          end
        end
        e_resp: begin
          if (io_resp_ready_i) begin
            resp_v_r <= 1'b0;
            state_r  <= e_idle;
          end
        end
        default: begin
          resp_v_r <= 1'b0;
          state_r  <= e_idle;
        end
      endcase
    end
  end

  // Backing store is deliberately left unreset so loaded images survive a reset
  always_ff @(posedge clk_i) begin
    if ((state_r == e_exec) && is_wr && !cfg_hit) begin
      if (is_size_8)
        mem[mem_idx] <= cmd_r.data;
      else if (hi_sel)
        mem[mem_idx][dword_width_p-1:half_width_lp] <= cmd_r.data[half_width_lp-1:0];
      else
        mem[mem_idx][half_width_lp-1:0] <= cmd_r.data[half_width_lp-1:0];
    end
  end

  assign io_cmd_yumi_o = (state_r == e_idle) && io_cmd_v_i;
  assign io_resp_o     = resp_r;
  assign io_resp_v_o   = resp_v_r;
  assign freeze_o      = freeze_r;
  assign wr_count_o    = wr_count_r;

endmodule

// File: tb/tb_bp_nonsynth_io_cfg_sink.sv
// Directed bench for bp_nonsynth_io_cfg_sink: vector table of single commands plus
// hand sequences for freeze timing, response back-pressure and reset during RESP.
module tb_bp_nonsynth_io_cfg_sink;

  localparam logic [1:0]  RD = 2'b00, WR = 2'b01, UNK = 2'b10;
  localparam logic [1:0]  S1 = 2'b00, S4 = 2'b10, S8 = 2'b11;
  localparam logic [39:0] FRZ_ADDR = 40'h20_0000_0008;
  localparam logic [39:0] CFG_OTHER = 40'h20_0000_0010;
  localparam logic [3:0]  PAYLOAD = 4'h5;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [111:0] io_cmd_i;
  logic         io_cmd_v_i;
  logic         io_cmd_yumi_o;
  logic [111:0] io_resp_o;
  logic         io_resp_v_o;
  logic         io_resp_ready_i;
  logic         freeze_o;
  logic [31:0]  wr_count_o;

  always #5 clk_i = ~clk_i;

  bp_nonsynth_io_cfg_sink dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .io_cmd_i       (io_cmd_i),
    .io_cmd_v_i     (io_cmd_v_i),
    .io_cmd_yumi_o  (io_cmd_yumi_o),
    .io_resp_o      (io_resp_o),
    .io_resp_v_o    (io_resp_v_o),
    .io_resp_ready_i(io_resp_ready_i),
    .freeze_o       (freeze_o),
    .wr_count_o     (wr_count_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [39:0] a;
    logic [1:0]  sz;
    logic [63:0] d;
    logic [63:0] exp_d;
    logic        exp_frz;
    logic [31:0] exp_wc;
  } vec_t;

  vec_t vecs[18];

  // Returns the response seen and the number of edges from acceptance to response valid
  task automatic run_cmd(input logic [1:0] t, input logic [39:0] a, input logic [1:0] sz,
                         input logic [63:0] d, output logic [111:0] resp, output int lat);
    int n;
    @(negedge clk_i);
    io_cmd_i        = {t, a, sz, PAYLOAD, d};
    io_cmd_v_i      = 1'b1;
    io_resp_ready_i = 1'b1;
    #1;
    n = 0;
    while (!io_cmd_yumi_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!io_cmd_yumi_o) begin
      check("yumi_timeout", 64'(io_cmd_yumi_o), 64'd1);
      io_cmd_v_i = 1'b0;
      resp = '0;
      lat  = -1;
    end else begin
      @(negedge clk_i);
      io_cmd_v_i = 1'b0;
      lat = 1;
      while (!io_resp_v_o && lat < 20) begin
        @(negedge clk_i);
        lat++;
      end
      resp = io_resp_o;
    end
  endtask

  logic [111:0] resp, hold;
  int lat;

  initial begin
    vecs[0]  = '{WR,  40'h80,   S8, 64'h1122_3344_5566_7788, 64'h0,                   1'b1, 32'd1};
    vecs[1]  = '{RD,  40'h80,   S8, 64'h0,                   64'h1122_3344_5566_7788, 1'b1, 32'd1};
    vecs[2]  = '{WR,  40'h84,   S4, 64'hAAAA_AAAA_DEAD_BEEF, 64'h0,                   1'b1, 32'd2};
    vecs[3]  = '{RD,  40'h80,   S8, 64'h0,                   64'hDEAD_BEEF_5566_7788, 1'b1, 32'd2};
    vecs[4]  = '{RD,  40'h84,   S4, 64'h0,                   64'h0000_0000_DEAD_BEEF, 1'b1, 32'd2};
    vecs[5]  = '{RD,  40'h80,   S4, 64'h0,                   64'h0000_0000_5566_7788, 1'b1, 32'd2};
    vecs[6]  = '{WR,  40'h80,   S1, 64'h1234_5678_CAFE_F00D, 64'h0,                   1'b1, 32'd3};
    vecs[7]  = '{RD,  40'h80,   S8, 64'h0,                   64'hDEAD_BEEF_CAFE_F00D, 1'b1, 32'd3};
    vecs[8]  = '{RD,  FRZ_ADDR, S8, 64'h0,                   64'h1,                   1'b1, 32'd3};
    vecs[9]  = '{RD,  CFG_OTHER,S8, 64'h0,                   64'h0,                   1'b1, 32'd3};
    vecs[10] = '{WR,  CFG_OTHER,S8, 64'h0,                   64'h0,                   1'b1, 32'd4};
    vecs[11] = '{WR,  FRZ_ADDR, S8, 64'h0,                   64'h0,                   1'b0, 32'd5};
    vecs[12] = '{RD,  FRZ_ADDR, S8, 64'h0,                   64'h0,                   1'b0, 32'd5};
    vecs[13] = '{WR,  40'h2008, S8, 64'h0123_4567_89AB_CDEF, 64'h0,                   1'b0, 32'd6};
    vecs[14] = '{RD,  40'h8,    S8, 64'h0,                   64'h0123_4567_89AB_CDEF, 1'b0, 32'd6};
    vecs[15] = '{UNK, 40'h8,    S8, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 1'b0, 32'd6};
    vecs[16] = '{RD,  40'h2008, S8, 64'h0,                   64'h0123_4567_89AB_CDEF, 1'b0, 32'd6};
    vecs[17] = '{WR,  FRZ_ADDR, S8, 64'h1,                   64'h0,                   1'b1, 32'd7};

    reset_n_i       = 1'b0;
    io_cmd_i        = '0;
    io_cmd_v_i      = 1'b0;
    io_resp_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("idle_freeze", 64'(freeze_o), 64'd1);
      check("idle_resp_v", 64'(io_resp_v_o), 64'd0);
      check("idle_wr_count", 64'(wr_count_o), 64'd0);
    end

    for (int i = 0; i < 18; i++) begin
      run_cmd(vecs[i].t, vecs[i].a, vecs[i].sz, vecs[i].d, resp, lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd2);
      check($sformatf("v%0d_data", i), resp[63:0], vecs[i].exp_d);
      check($sformatf("v%0d_header", i), 64'(resp[111:64]),
            64'({vecs[i].t, vecs[i].a, vecs[i].sz, PAYLOAD}));
      check($sformatf("v%0d_freeze", i), 64'(freeze_o), 64'(vecs[i].exp_frz));
      check($sformatf("v%0d_wr_count", i), 64'(wr_count_o), 64'(vecs[i].exp_wc));
    end

    // Freeze clears exactly on the EXEC edge; then back-pressure the response
    @(negedge clk_i);
    io_cmd_i        = {WR, FRZ_ADDR, S8, PAYLOAD, 64'h0};
    io_cmd_v_i      = 1'b1;
    io_resp_ready_i = 1'b0;
    #1;
    check("frz_yumi_idle", 64'(io_cmd_yumi_o), 64'd1);
    @(negedge clk_i);
    check("frz_exec_yumi", 64'(io_cmd_yumi_o), 64'd0);
    check("frz_exec_freeze", 64'(freeze_o), 64'd1);
    check("frz_exec_resp_v", 64'(io_resp_v_o), 64'd0);
    @(negedge clk_i);
    check("frz_resp_freeze", 64'(freeze_o), 64'd0);
    check("frz_resp_v", 64'(io_resp_v_o), 64'd1);
    check("frz_wr_count", 64'(wr_count_o), 64'd8);
    hold = io_resp_o;
    check("frz_resp_header", 64'(hold[111:64]), 64'({WR, FRZ_ADDR, S8, PAYLOAD}));
    check("frz_resp_data", hold[63:0], 64'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check($sformatf("stall%0d_data", i), io_resp_o[63:0], hold[63:0]);
      check($sformatf("stall%0d_header", i), 64'(io_resp_o[111:64]), 64'(hold[111:64]));
      check($sformatf("stall%0d_resp_v", i), 64'(io_resp_v_o), 64'd1);
      check($sformatf("stall%0d_yumi", i), 64'(io_cmd_yumi_o), 64'd0);
    end
    io_resp_ready_i = 1'b1;
    #1;
    check("ready_rise_resp_v", 64'(io_resp_v_o), 64'd1);
    @(negedge clk_i);
    check("ready_done_resp_v", 64'(io_resp_v_o), 64'd0);
    check("ready_done_yumi", 64'(io_cmd_yumi_o), 64'd1);
    io_cmd_v_i = 1'b0;

    // Reset while a response is pending
    @(negedge clk_i);
    io_cmd_i        = {WR, 40'h100, S8, PAYLOAD, 64'h5};
    io_cmd_v_i      = 1'b1;
    io_resp_ready_i = 1'b0;
    @(negedge clk_i);
    io_cmd_v_i = 1'b0;
    @(negedge clk_i);
    check("rst_pre_resp_v", 64'(io_resp_v_o), 64'd1);
    check("rst_pre_freeze", 64'(freeze_o), 64'd0);
    reset_n_i = 1'b0;
    #1;
    check("rst_resp_v", 64'(io_resp_v_o), 64'd0);
    check("rst_freeze", 64'(freeze_o), 64'd1);
    check("rst_wr_count", 64'(wr_count_o), 64'd0);
    check("rst_resp_msg", 64'(io_resp_o[111:64]), 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    run_cmd(RD, 40'h8, S8, 64'h0, resp, lat);
    check("post_rst_store", resp[63:0], 64'h0123_4567_89AB_CDEF);
    run_cmd(RD, 40'h100, S8, 64'h0, resp, lat);
    check("post_rst_inflight_wr", resp[63:0], 64'h5);
    check("post_rst_wr_count", 64'(wr_count_o), 64'd0);
    check("post_rst_latency", 64'(lat), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_nonsynth_io_cfg_sink.md
Name: bp_nonsynth_io_cfg_sink

Overview:
- Nonsynthesizable IO endpoint that sits directly downstream of the NBF loader in the testbench. It consumes bp_cce_io_msg_s commands and returns one response per command.
- Commands that decode to the config device update a freeze register; all other commands read or write a small dword backing store.
- freeze_o drives the processor's freeze input. It starts asserted and is released when the loader's final freeze-clear write arrives.

Parameters:
- bp_params_p, e_bp_inv_cfg, processor configuration; supplies paddr_width_p, dword_width_p, lce_id_width_p, cce_io_msg_width_lp.
- mem_els_p, 1024, number of dword_width_p entries in the backing store; must be a power of 2.
- cfg_dev_width_p, 4, number of upper address bits compared against cfg_dev_gp.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- io_cmd_i  input  cce_io_msg_width_lp  command message (bp_cce_io_msg_s).
- io_cmd_v_i  input  1  command valid.
- io_cmd_yumi_o  output  1  command consumed this cycle.
- io_resp_o  output  cce_io_msg_width_lp  response message.
- io_resp_v_o  output  1  response valid.
- io_resp_ready_i  input  1  downstream can accept a response.
- freeze_o  output  1  freeze register value.
- wr_count_o  output  32  number of completed writes; saturating.

Behaviour:
- Reset (asynchronous assert of reset_n_i low):
  - state goes to IDLE; io_cmd_yumi_o=0, io_resp_v_o=0.
  - freeze_o=1, wr_count_o=0, latched command cleared to 0.
  - Backing store contents are not reset.
  - Applies at any point, including EXEC or RESP; an in-flight response is dropped.
- State machine, states IDLE, EXEC, RESP:
  - IDLE: io_cmd_yumi_o = io_cmd_v_i, combinational. yumi is never asserted without valid. On yumi, latch io_cmd_i and go to EXEC.
  - EXEC: exactly one cycle. Perform the decode and the read or write, register the response, go to RESP.
  - RESP: io_resp_v_o=1. io_resp_o is held stable until io_resp_ready_i=1, then go to IDLE.
- Latency and throughput:
  - Command accepted at edge N; io_resp_v_o first high in the cycle after edge N+1.
  - With io_resp_ready_i held high, one command completes every 3 cycles.
  - No new command is accepted outside IDLE; yumi stays 0 in EXEC and RESP.
- Decode:
  - cfg hit = addr[paddr_width_p-1 -: cfg_dev_width_p] == cfg_dev_gp.
  - cfg_addr = addr[cfg_addr_width_p-1:0].
  - Memory index = addr[3 +: log2(mem_els_p)]; higher address bits are ignored, so the index wraps modulo mem_els_p.
- Config writes:
  - Write to cfg_addr == bp_cfg_reg_freeze_gp: freeze_o <= data[0], updated at the EXEC edge.
  - Write to any other cfg_addr: discarded, but still counted and still answered.
- Config reads:
  - Freeze register returns {63'b0, freeze_o}.
  - Any other cfg_addr returns 0.
- Memory writes:
  - e_io_size_8: full dword written.
  - e_io_size_4: addr[2]=0 writes bits [31:0], addr[2]=1 writes bits [63:32]; the other half is unchanged. Data comes from data[31:0].
  - Any other size is treated as e_io_size_4.
- Memory reads:
  - e_io_size_8 returns the full dword.
  - e_io_size_4 returns the selected half, zero-extended.
- Response message:
  - msg_type, addr, size and payload are copied from the latched command.
  - data = 0 for writes; read data for e_cce_io_rd.
- wr_count_o:
  - Increments at the EXEC edge for every e_cce_io_wr, cfg or memory.
  - Saturates at 32'hFFFF_FFFF.
- Unknown msg_type: treated as a read.

Test Plan:
- Release reset with no commands -> freeze_o=1, io_resp_v_o=0, wr_count_o=0 for 10 cycles.
- e_io_size_8 write 0x1122_3344_5566_7788 to addr 0x80, then a read of addr 0x80 -> write response data=0; read response data=0x1122334455667788; wr_count_o=1.
- e_io_size_4 write 0xDEADBEEF to addr 0x84 after the previous step -> a size_8 read of 0x80 returns 0xDEADBEEF55667788.
- Write data=0 to {cfg_dev_gp, bp_cfg_reg_freeze_gp} -> freeze_o falls on the EXEC edge; a read of the same address returns 0.
- Hold io_resp_ready_i=0 for 5 cycles during RESP -> io_resp_o is stable and io_cmd_yumi_o=0 even with io_cmd_v_i=1; the response completes one cycle after ready rises.
- Write to index mem_els_p+1, then read index 1 -> same data returned (wrap). Then drop reset_n_i during RESP -> io_resp_v_o=0 immediately and freeze_o=1.
